// File: rtl/spm_mp_ctrl_pkg.sv
// Shared constants and types for the multi-master scratch-pad memory controller.
package spm_mp_ctrl_pkg;

   typedef enum logic {
      ACC_READ  = 1'b0,
      ACC_WRITE = 1'b1
   } acc_e;

   localparam int SPM_DEPTH_DFLT = 4096;
   localparam int BYTE_W         = 8;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spm_mp_ctrl_arbiter.sv
// Fixed or rotating-priority request arbiter with a last-grant pointer register.
module rr_arbiter
   import spm_mp_ctrl_pkg::*;
#(
   parameter int N       = 3,
   parameter bit RR_MODE = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        req,
   input  logic                advance,
   output logic [N-1:0]        gnt,
   output logic [idx_w(N)-1:0] last_gnt
);

   localparam int IW = idx_w(N);

   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] cand;

   // Scan from the farthest candidate to the nearest so the nearest requester wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      gnt     = '0;
      gnt_idx = last_gnt;
      cand    = '0;
      if (RR_MODE) begin
         for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_gnt) + k) % N);
            if (req[cand]) begin
               gnt       = '0;
               gnt[cand] = 1'b1;
               gnt_idx   = cand;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt     = '0;
               gnt[i]  = 1'b1;
               gnt_idx = IW'(i);
            end
         end
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt <= IW'(N - 1);
      end else if (advance) begin
         last_gnt <= gnt_idx;
      end
   end

endmodule

// File: rtl/spm_mp_ctrl.sv
// Scratch-pad memory shared by N arbitrated masters with byte-enable writes and range errors.
module spm_mp_ctrl
   import spm_mp_ctrl_pkg::*;
#(
   parameter int N_MST   = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 30,
   parameter int DEPTH   = SPM_DEPTH_DFLT,
   parameter bit RR_MODE = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MST-1:0]             m_req,
   input  logic [N_MST-1:0]             m_we,
   input  logic [N_MST*DATA_W/8-1:0]    m_be,
   input  logic [N_MST*ADDR_W-1:0]      m_addr,
   input  logic [N_MST*DATA_W-1:0]      m_wdata,
   output logic [N_MST-1:0]             m_gnt,
   output logic [N_MST-1:0]             m_rvalid,
   output logic [N_MST-1:0]             m_err,
   output logic [DATA_W-1:0]            m_rdata
);

   localparam int BE_W   = DATA_W / BYTE_W;
   localparam int IW     = idx_w(N_MST);
   localparam int MEM_AW = idx_w(DEPTH);

   logic [N_MST-1:0]  arb_gnt;
   logic [IW-1:0]     last_gnt;
   logic              sel_we;
   logic [BE_W-1:0]   sel_be;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              fire, in_range, do_wr, do_rd;
   logic [MEM_AW-1:0] mem_idx;
   logic              rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic [DATA_W-1:0] mem [DEPTH];

   rr_arbiter #(.N(N_MST), .RR_MODE(RR_MODE)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (m_req),
      .advance  (fire),
      .gnt      (arb_gnt),
      .last_gnt (last_gnt)
   );

   assign m_gnt = reset ? '0 : arb_gnt;
   assign fire  = |m_gnt;

   // The grant is one-hot, so an AND-OR mux selects the winning channel.
   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_MST; i++) begin
         sel_we    = sel_we    | (m_we[i] & m_gnt[i]);
         sel_be    = sel_be    | (m_be[i*BE_W +: BE_W]         & {BE_W{m_gnt[i]}});
         sel_addr  = sel_addr  | (m_addr[i*ADDR_W +: ADDR_W]   & {ADDR_W{m_gnt[i]}});
         sel_wdata = sel_wdata | (m_wdata[i*DATA_W +: DATA_W]  & {DATA_W{m_gnt[i]}});
      end
   end

   assign in_range = 64'(sel_addr) < 64'(DEPTH);
   assign mem_idx  = sel_addr[MEM_AW-1:0];
   assign do_wr    = fire & in_range & (acc_e'(sel_we) == ACC_WRITE);
   assign do_rd    = fire & in_range & (acc_e'(sel_we) == ACC_READ);

   // NOTE: the array is deliberately not reset; only the response path is.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         for (int k = 0; k < BE_W; k++) begin
            if (sel_be[k]) begin
               mem[mem_idx][k*BYTE_W +: BYTE_W] <= sel_wdata[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= fire;
         rsp_err   <= fire & ~in_range;
         rsp_rdata <= do_rd ? mem[mem_idx] : '0;
      end
   end

   // The arbiter pointer was loaded with the granted channel at the accepting edge,
   // so it names the responding channel while rsp_valid is set.
   always_comb begin
      m_rvalid = '0;
      m_err    = '0;
      if (rsp_valid) begin
         m_rvalid[last_gnt] = 1'b1;
         m_err[last_gnt]    = rsp_err;
      end
   end

   assign m_rdata = rsp_rdata;

endmodule

// File: tb/tb_spm_mp_ctrl.sv
// Self-checking bench: behavioural arbitration/memory model plus directed literal checks.
module tb_spm_mp_ctrl;

   localparam int N     = 3;
   localparam int DW    = 32;
   localparam int AW    = 30;
   localparam int BEW   = 4;
   localparam int DEPTH = 4096;
   localparam int NMOD  = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    m_req, m_we;
   logic [N*BEW-1:0] m_be;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N-1:0]    m_gnt, m_rvalid, m_err;
   logic [DW-1:0]   m_rdata;
   logic [N-1:0]    gnt_fix, rv_fix, err_fix;
   logic [DW-1:0]   rdata_fix;

   always #5 clk = ~clk;

   spm_mp_ctrl #(.N_MST(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RR_MODE(1'b1)) dut (
      .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
      .m_err(m_err), .m_rdata(m_rdata)
   );

   spm_mp_ctrl #(.N_MST(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RR_MODE(1'b0)) dut_fix (
      .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(gnt_fix), .m_rvalid(rv_fix),
      .m_err(err_fix), .m_rdata(rdata_fix)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: memory image of the low addresses, pointer, pending response.
   logic [DW-1:0] mm [NMOD];
   int            last;
   logic [N-1:0]  exp_rv, exp_err;
   logic [DW-1:0] exp_rdata;
   bit            exp_rd_chk;
   logic [N-1:0]  obs_gnt, obs_gnt_fix, obs_rv, obs_err;
   logic [DW-1:0] obs_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round robin: the requester closest after the previous winner, cyclically.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int lst);
      int best = -1;
      int bd   = N;
      for (int i = 0; i < N; i++) begin
         if (req[i] && ((i - lst - 1 + N) % N) < bd) begin
            bd   = (i - lst - 1 + N) % N;
            best = i;
         end
      end
      return (best < 0) ? '0 : (N'(1) << best);
   endfunction

   // Fixed priority: isolate the lowest set bit.
   function automatic logic [N-1:0] fix_pick(input logic [N-1:0] req);
      logic [N-1:0] neg;
      neg = ~req + N'(1);
      return req & neg;
   endfunction

   task automatic idle();
      m_req   = '0;
      m_we    = N'($urandom());
      m_be    = (N*BEW)'($urandom());
      m_addr  = (N*AW)'({$urandom(), $urandom(), $urandom()});
      m_wdata = {$urandom(), $urandom(), $urandom()};
   endtask

   task automatic set_ch(input int ch, input logic we, input logic [BEW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_req[ch]             = 1'b1;
      m_we[ch]              = we;
      m_be[ch*BEW +: BEW]   = be;
      m_addr[ch*AW +: AW]   = a;
      m_wdata[ch*DW +: DW]  = d;
   endtask

   // One clock cycle: compare at the falling edge, then advance the model.
   task automatic run_cycle(input logic rst);
      logic [N-1:0]  e_gnt;
      logic [AW-1:0] a;
      logic [BEW-1:0] be;
      logic [DW-1:0] wd;
      int            ch;
      reset = rst;
      @(negedge clk);
      obs_gnt     = m_gnt;
      obs_gnt_fix = gnt_fix;
      obs_rv      = m_rvalid;
      obs_err     = m_err;
      obs_rdata   = m_rdata;
      check("rvalid", m_rvalid, exp_rv);
      check("err", m_err, exp_err);
      if (exp_rd_chk) check("rdata", m_rdata, exp_rdata);
      e_gnt = rst ? '0 : rr_pick(m_req, last);
      check("gnt_rr", m_gnt, e_gnt);
      check("gnt_fixed", gnt_fix, rst ? '0 : fix_pick(m_req));

      exp_rv     = '0;
      exp_err    = '0;
      exp_rdata  = '0;
      exp_rd_chk = 1'b1;
      ch         = 0;
      if (rst) begin
         last = N - 1;
      end else if (e_gnt != '0) begin
         for (int i = 0; i < N; i++) if (e_gnt[i]) ch = i;
         a  = m_addr[ch*AW +: AW];
         be = m_be[ch*BEW +: BEW];
         wd = m_wdata[ch*DW +: DW];
         exp_rv = e_gnt;
         if (a >= AW'(DEPTH)) begin
            exp_err = e_gnt;
         end else if (m_we[ch]) begin
            exp_rd_chk = 1'b0;
            for (int k = 0; k < BEW; k++)
               if (be[k]) mm[int'(a)][k*8 +: 8] = wd[k*8 +: 8];
         end else begin
            exp_rdata = mm[int'(a)];
         end
         last = ch;
      end
      @(posedge clk);
      #1;
   endtask

   logic          pv  [N];
   logic          pwe [N];
   logic [3:0]    pbe [N];
   logic [AW-1:0] pa  [N];
   logic [DW-1:0] pd  [N];
   logic [N-1:0]  all_rr [6];

   initial begin
      logic [DW-1:0] v;
      all_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      last = N - 1;
      exp_rv = '0; exp_err = '0; exp_rdata = '0; exp_rd_chk = 1'b1;
      check("reset_rvalid", m_rvalid, 3'b000);
      check("reset_err", m_err, 3'b000);
      check("reset_rdata", m_rdata, 32'h0);
      run_cycle(1'b0);

      // Preload the low addresses through channel 0.
      for (int a = 0; a < NMOD; a++) begin
         v = (a == 0) ? 32'h0BADF00D : (a == 3) ? 32'h33333333 :
             (a == 5) ? 32'hDEADBEEF : (a == 7) ? 32'h11223344 : $urandom();
         idle(); set_ch(0, 1'b1, 4'hF, AW'(a), v);
         run_cycle(1'b0);
      end
      idle(); run_cycle(1'b0);

      // Single read.
      idle(); set_ch(1, 1'b0, 4'h0, 30'd5, 32'h0);
      run_cycle(1'b0);
      check("rd_gnt", obs_gnt, 3'b010);
      idle(); run_cycle(1'b0);
      check("rd_rvalid", obs_rv, 3'b010);
      check("rd_data", obs_rdata, 32'hDEADBEEF);

      // Byte-enable write then read back.
      idle(); set_ch(0, 1'b1, 4'b0101, 30'd7, 32'hAABBCCDD); run_cycle(1'b0);
      idle(); set_ch(0, 1'b0, 4'h0, 30'd7, 32'h0);           run_cycle(1'b0);
      idle(); run_cycle(1'b0);
      check("be_data", obs_rdata, 32'h11BB33DD);

      // Contention from reset: rotating vs fixed.
      idle(); run_cycle(1'b1);
      for (int c = 0; c < 6; c++) begin
         idle();
         for (int ch = 0; ch < N; ch++) set_ch(ch, 1'b0, 4'h0, AW'(ch + 1), 32'h0);
         run_cycle(1'b0);
         check("rr_seq", obs_gnt, all_rr[c]);
         check("fixed_seq", obs_gnt_fix, 3'b001);
      end
      idle(); run_cycle(1'b0);

      // Out-of-range write, then the aliased low address is untouched.
      idle(); set_ch(2, 1'b1, 4'hF, 30'd4096, 32'hFFFFFFFF); run_cycle(1'b0);
      check("oor_gnt", obs_gnt, 3'b100);
      idle(); set_ch(0, 1'b0, 4'h0, 30'd0, 32'h0); run_cycle(1'b0);
      check("oor_rvalid", obs_rv, 3'b100);
      check("oor_err", obs_err, 3'b100);
      check("oor_rdata", obs_rdata, 32'h0);
      idle(); run_cycle(1'b0);
      check("oor_alias", obs_rdata, 32'h0BADF00D);

      // Read after write, back to back.
      idle(); set_ch(0, 1'b1, 4'hF, 30'd9, 32'h5); run_cycle(1'b0);
      idle(); set_ch(1, 1'b0, 4'h0, 30'd9, 32'h0); run_cycle(1'b0);
      check("raw_ack", obs_rv, 3'b001);
      idle(); run_cycle(1'b0);
      check("raw_rvalid", obs_rv, 3'b010);
      check("raw_data", obs_rdata, 32'h5);

      // Reset in the same cycle as a write grant.
      idle(); set_ch(0, 1'b1, 4'hF, 30'd3, 32'hFF); run_cycle(1'b1);
      check("rst_gnt", obs_gnt, 3'b000);
      idle();
      for (int ch = 0; ch < N; ch++) set_ch(ch, 1'b0, 4'h0, 30'd3, 32'h0);
      run_cycle(1'b0);
      check("rst_no_rsp", obs_rv, 3'b000);
      check("rst_first", obs_gnt, 3'b001);
      idle(); run_cycle(1'b0);
      check("rst_mem", obs_rdata, 32'h33333333);

      // Randomized traffic against the model.
      for (int ch = 0; ch < N; ch++) pv[ch] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         idle();
         for (int ch = 0; ch < N; ch++) begin
            if (!pv[ch]) begin
               pv[ch]  = ($urandom_range(99) < 50);
               pwe[ch] = 1'($urandom());
               pbe[ch] = 4'($urandom());
               pd[ch]  = $urandom();
               case ($urandom_range(19))
                  0:       pa[ch] = 30'h3FFFFFFF;
                  1:       pa[ch] = AW'(DEPTH + $urandom_range(15));
                  2:       pa[ch] = 30'd4200;
                  default: pa[ch] = AW'($urandom_range(NMOD - 1));
               endcase
            end else if ($urandom_range(99) < 8) begin
               pv[ch] = 1'b0;
            end
            if (pv[ch]) set_ch(ch, pwe[ch], pbe[ch], pa[ch], pd[ch]);
         end
         run_cycle($urandom_range(63) == 0);
         for (int ch = 0; ch < N; ch++) if (obs_gnt[ch]) pv[ch] = 1'b0;
      end
      idle(); run_cycle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
